// File: rtl/mem_block_mover_pkg.sv
// Shared definitions for the block mover: state encoding, bus widths and default memory depth.
package mem_block_mover_pkg;

  localparam int unsigned MEM_SIZE_DEF = 128;
  localparam int unsigned ADR_W        = 8;
  localparam int unsigned DATA_W       = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DUMP  = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

endpackage

// File: rtl/mem_block_mover_if.sv
// Control and memory-port bundle between the block mover (master) and its requester/memory (slave).
interface mem_block_mover_if;
  import mem_block_mover_pkg::*;

  logic              start;
  logic [ADR_W-1:0]  src_adr;
  logic [ADR_W-1:0]  dst_adr;
  logic [ADR_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [ADR_W-1:0]  rd_adr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADR_W-1:0]  wr_adr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_file;

  modport master (
    input  start, src_adr, dst_adr, len, rd_data,
    output busy, done, rd_adr, wr_en, wr_adr, wr_data, wr_file
  );

  modport slave (
    output start, src_adr, dst_adr, len, rd_data,
    input  busy, done, rd_adr, wr_en, wr_adr, wr_data, wr_file
  );

endinterface

// File: rtl/mem_block_mover.sv
// Word-by-word memory block copy engine with overlap-safe direction choice and optional dump pulse.
// All outputs are registered; output values are derived from the next state.
module mem_block_mover
  import mem_block_mover_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEF,
  parameter bit          DUMP_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  mem_block_mover_if.master bus
);

  state_e            state_q, state_d;
  logic [ADR_W-1:0]  src_q, src_d;
  logic [ADR_W-1:0]  dst_q, dst_d;
  logic [ADR_W-1:0]  cnt_q, cnt_d;
  logic [ADR_W-1:0]  idx_q, idx_d;
  logic              desc_q, desc_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [ADR_W-1:0]  rd_adr_q, rd_adr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADR_W-1:0]  wr_adr_q, wr_adr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_file_q, wr_file_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overlap_s;

  function automatic logic [ADR_W-1:0] mod_adr(input logic [ADR_W-1:0] a);
    logic [ADR_W:0] w;
    w = {1'b0, a} % (ADR_W+1)'(MEM_SIZE);
    return w[ADR_W-1:0];
  endfunction

  // Destination starting inside the unwrapped source window must copy back-to-front.
  assign overlap_s = ({1'b0, bus.dst_adr} > {1'b0, bus.src_adr}) &&
                     ({1'b0, bus.dst_adr} < ({1'b0, bus.src_adr} + {1'b0, bus.len}));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      src_q     <= 8'd0;
      dst_q     <= 8'd0;
      cnt_q     <= 8'd0;
      idx_q     <= 8'd0;
      desc_q    <= 1'b0;
      hold_q    <= 32'd0;
      rd_adr_q  <= 8'd0;
      wr_en_q   <= 1'b0;
      wr_adr_q  <= 8'd0;
      wr_data_q <= 32'd0;
      wr_file_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      desc_q    <= desc_d;
      hold_q    <= hold_d;
      rd_adr_q  <= rd_adr_d;
      wr_en_q   <= wr_en_d;
      wr_adr_q  <= wr_adr_d;
      wr_data_q <= wr_data_d;
      wr_file_q <= wr_file_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.len == 8'd0) ? ST_FIN : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ:  state_d = ST_WRITE;
      ST_WRITE: begin
        if (cnt_q == 8'd1) begin
          state_d = DUMP_EN ? ST_DUMP : ST_FIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DUMP:  state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Argument latching, word count and index stepping
  always_comb begin
    src_d  = src_q;
    dst_d  = dst_q;
    cnt_d  = cnt_q;
    idx_d  = idx_q;
    desc_d = desc_q;
    hold_d = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          src_d  = bus.src_adr;
          dst_d  = bus.dst_adr;
          cnt_d  = bus.len;
          desc_d = overlap_s;
          idx_d  = overlap_s ? (bus.len - 8'd1) : 8'd0;
        end else begin
          desc_d = desc_q;
        end
      end
      ST_READ: hold_d = bus.rd_data;
      ST_WRITE: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q != 8'd1) begin
          idx_d = desc_q ? (idx_q - 8'd1) : (idx_q + 8'd1);
        end else begin
          idx_d = idx_q;
        end
      end
      default: hold_d = hold_q;
    endcase
  end

  // Output values for the cycle being entered; addresses hold outside their phase
  always_comb begin
    rd_adr_d  = (state_d == ST_READ)  ? mod_adr(src_d + idx_d) : rd_adr_q;
    wr_adr_d  = (state_d == ST_WRITE) ? mod_adr(dst_q + idx_q) : wr_adr_q;
    wr_data_d = (state_d == ST_WRITE) ? hold_d : wr_data_q;
    wr_en_d   = (state_d == ST_WRITE);
    wr_file_d = (state_d == ST_DUMP);
    done_d    = (state_d == ST_FIN);
    busy_d    = (state_d == ST_READ) || (state_d == ST_WRITE) || (state_d == ST_DUMP);
  end

  assign bus.rd_adr  = rd_adr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_adr  = wr_adr_q;
  assign bus.wr_data = wr_data_q;
  assign bus.wr_file = wr_file_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_mem_block_mover.sv
// Directed bench for mem_block_mover: behavioural memory, cycle-numbered transfers, hand-computed expectations.
module tb_mem_block_mover;

  localparam logic [31:0] VA = 32'hAAAA_0001;
  localparam logic [31:0] VB = 32'hBBBB_0002;
  localparam logic [31:0] VC = 32'hCCCC_0003;
  localparam logic [31:0] VD = 32'hDDDD_0004;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_clr;
  logic        ld_en;
  logic [7:0]  ld_adr;
  logic [31:0] ld_dat;
  logic [31:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;
  int done_cyc, file_cyc, excl_err, busy_cnt;
  logic [7:0] wr_log [$];
  logic [7:0] rd_log [$];

  mem_block_mover_if bif ();

  mem_block_mover #(.MEM_SIZE(128), .DUMP_EN(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  assign bif.rd_data = mem[bif.rd_adr];

  // Memory model: bench loads/clears while idle, DUT writes otherwise
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    end else if (ld_en) begin
      mem[ld_adr] <= ld_dat;
    end else if (bif.wr_en) begin
      mem[bif.wr_adr] <= bif.wr_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    mem_clr = 1'b1;
    @(negedge clk);
    mem_clr = 1'b0;
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_adr = a; ld_dat = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic load_abcd(input logic [7:0] base);
    load(base, VA); load(base + 8'd1, VB); load(base + 8'd2, VC); load(base + 8'd3, VD);
  endtask

  // Cycle 0 is the one where start is sampled; each later negedge observes cycle cyc.
  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input int inj_cyc, input int abort_cyc);
    wr_log.delete(); rd_log.delete();
    done_cyc = -1; file_cyc = -1; excl_err = 0; busy_cnt = 0;
    @(negedge clk);
    bif.start = 1'b1; bif.src_adr = s; bif.dst_adr = d; bif.len = l;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == inj_cyc) begin
        bif.start = 1'b1; bif.src_adr = 8'd50; bif.dst_adr = 8'd60; bif.len = 8'd1;
      end else begin
        bif.start = 1'b0;
      end
      if (bif.wr_en) wr_log.push_back(bif.wr_adr);
      if (bif.wr_file) file_cyc = cyc;
      if (bif.busy) busy_cnt++;
      if ((cyc % 2 == 1) && bif.busy && !bif.wr_file) rd_log.push_back(bif.rd_adr);
      if (32'(bif.wr_en) + 32'(bif.wr_file) + 32'(bif.done) > 32'd1) excl_err++;
      if (bif.done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == abort_cyc) begin
        rst = 1'b1;
        break;
      end
    end
  endtask

  task automatic chk_log(input string tag, input bit use_rd, input int n,
                         input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    int sz;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    sz = use_rd ? rd_log.size() : wr_log.size();
    chk({tag, "_count"}, 32'(sz), 32'(n));
    for (int i = 0; i < n && i < sz; i++) begin
      chk(tag, 32'(use_rd ? rd_log[i] : wr_log[i]), 32'(e[i]));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},    32'(bif.busy),    32'd0);
    chk({tag, "_done"},    32'(bif.done),    32'd0);
    chk({tag, "_wr_en"},   32'(bif.wr_en),   32'd0);
    chk({tag, "_wr_file"}, 32'(bif.wr_file), 32'd0);
    chk({tag, "_rd_adr"},  32'(bif.rd_adr),  32'd0);
    chk({tag, "_wr_adr"},  32'(bif.wr_adr),  32'd0);
    chk({tag, "_wr_data"}, bif.wr_data,      32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; mem_clr = 1'b0; ld_en = 1'b0; ld_adr = 8'd0; ld_dat = 32'd0;
    bif.start = 1'b0; bif.src_adr = 8'd0; bif.dst_adr = 8'd0; bif.len = 8'd0;
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;

    // Basic copy, 4 words, disjoint ranges
    clear_mem(); load_abcd(8'd0);
    run_xfer(8'd0, 8'd16, 8'd4, -1, -1);
    chk("basic_done_cyc", 32'(done_cyc), 32'd10);
    chk("basic_file_cyc", 32'(file_cyc), 32'd9);
    chk("basic_busy_cycles", 32'(busy_cnt), 32'd9);
    chk("basic_excl", 32'(excl_err), 32'd0);
    chk_log("basic_wr_adr", 1'b0, 4, 8'd16, 8'd17, 8'd18, 8'd19);
    chk_log("basic_rd_adr", 1'b1, 4, 8'd0, 8'd1, 8'd2, 8'd3);
    chk("basic_m16", mem[16], VA); chk("basic_m17", mem[17], VB);
    chk("basic_m18", mem[18], VC); chk("basic_m19", mem[19], VD);
    @(negedge clk);
    chk("basic_done_pulse", 32'(bif.done), 32'd0);
    chk("basic_busy_after", 32'(bif.busy), 32'd0);

    // Overlapping forward move must copy descending
    clear_mem(); load_abcd(8'd0);
    run_xfer(8'd0, 8'd2, 8'd4, -1, -1);
    chk("ovl_done_cyc", 32'(done_cyc), 32'd10);
    chk_log("ovl_wr_adr", 1'b0, 4, 8'd5, 8'd4, 8'd3, 8'd2);
    chk_log("ovl_rd_adr", 1'b1, 4, 8'd3, 8'd2, 8'd1, 8'd0);
    chk("ovl_m2", mem[2], VA); chk("ovl_m3", mem[3], VB);
    chk("ovl_m4", mem[4], VC); chk("ovl_m5", mem[5], VD);
    chk("ovl_m0", mem[0], VA); chk("ovl_m1", mem[1], VB);

    // Source window wraps past the top of memory
    clear_mem();
    load(8'd126, VA); load(8'd127, VB); load(8'd0, VC); load(8'd1, VD);
    run_xfer(8'd126, 8'd10, 8'd4, -1, -1);
    chk_log("wrap_rd_adr", 1'b1, 4, 8'd126, 8'd127, 8'd0, 8'd1);
    chk_log("wrap_wr_adr", 1'b0, 4, 8'd10, 8'd11, 8'd12, 8'd13);
    chk("wrap_m10", mem[10], VA); chk("wrap_m11", mem[11], VB);
    chk("wrap_m12", mem[12], VC); chk("wrap_m13", mem[13], VD);

    // Zero length completes immediately with no writes or dump
    run_xfer(8'd5, 8'd6, 8'd0, -1, -1);
    chk("len0_done_cyc", 32'(done_cyc), 32'd1);
    chk("len0_writes", 32'(wr_log.size()), 32'd0);
    chk("len0_file_cyc", 32'(file_cyc), 32'hFFFF_FFFF);
    chk("len0_busy_cycles", 32'(busy_cnt), 32'd0);

    // In-place copy rewrites identical data
    clear_mem(); load(8'd20, VA); load(8'd21, VB);
    run_xfer(8'd20, 8'd20, 8'd2, -1, -1);
    chk("same_done_cyc", 32'(done_cyc), 32'd6);
    chk("same_file_cyc", 32'(file_cyc), 32'd5);
    chk_log("same_wr_adr", 1'b0, 2, 8'd20, 8'd21, 8'd0, 8'd0);
    chk("same_m20", mem[20], VA); chk("same_m21", mem[21], VB);

    // A start pulse while busy is ignored
    clear_mem(); load_abcd(8'd0);
    run_xfer(8'd0, 8'd16, 8'd4, 3, -1);
    chk("busy_start_done_cyc", 32'(done_cyc), 32'd10);
    chk("busy_start_file_cyc", 32'(file_cyc), 32'd9);
    chk_log("busy_start_wr_adr", 1'b0, 4, 8'd16, 8'd17, 8'd18, 8'd19);
    chk("busy_start_m19", mem[19], VD);
    chk("busy_start_m60", mem[60], 32'd0);

    // Reset in cycle 3 aborts after the first word, then a fresh transfer works
    clear_mem(); load_abcd(8'd0);
    run_xfer(8'd0, 8'd32, 8'd4, -1, 3);
    @(negedge clk);
    chk_outputs_zero("abort");
    rst = 1'b0;
    chk("abort_writes", 32'(wr_log.size()), 32'd1);
    chk("abort_m32", mem[32], VA);
    chk("abort_m33", mem[33], 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_idle_wr_en", 32'(bif.wr_en), 32'd0);
    run_xfer(8'd0, 8'd40, 8'd2, -1, -1);
    chk("restart_done_cyc", 32'(done_cyc), 32'd6);
    chk("restart_m40", mem[40], VA);
    chk("restart_m41", mem[41], VB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
